// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU select codes, aluop codes and funct codes.
package ex_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/ex_stage_alu.sv
// Team ALU: purely combinational datapath selected by an alu_sel_e code.
module ex_stage_alu
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_sel_e           sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result
);

    // Select the operation; add/sub wrap naturally, slt is a signed compare.
    always_comb begin
        result = '0;
        case (sel)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX entry register, ALU decode, optional operand forwarding
// (enabled by macro EX_STAGE_FWD_EN), and EX/MEM output register with a
// valid/ready handshake on both sides.
module ex_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [WIDTH-1:0]   id_rs_val,
    input  logic [WIDTH-1:0]   id_rt_val,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               id_alusrc,
    input  logic [1:0]         id_aluop,
    input  logic [5:0]         id_funct,
    input  logic               id_regwrite,
    input  logic               wb_we,
    input  logic [4:0]         wb_rd,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               ex_valid,
    input  logic               mem_ready,
    output logic [WIDTH-1:0]   ex_result,
    output logic               ex_zero,
    output logic [4:0]         ex_rd,
    output logic               ex_regwrite,
    output logic               ex_illegal
);

    logic               idex_valid;
    logic [WIDTH-1:0]   idex_rs_val;
    logic [WIDTH-1:0]   idex_rt_val;
    logic [WIDTH-1:0]   idex_imm;
    logic [4:0]         idex_rs;
    logic [4:0]         idex_rt;
    logic [4:0]         idex_rd;
    logic               idex_alusrc;
    logic [1:0]         idex_aluop;
    logic [5:0]         idex_funct;
    logic               idex_regwrite;

    logic               advance;
    logic               accept;
    logic [WIDTH-1:0]   fwd_rs;
    logic [WIDTH-1:0]   fwd_rt;
    logic [WIDTH-1:0]   op_b;
    alu_sel_e           alu_sel;
    logic               illegal;
    logic [WIDTH-1:0]   alu_result;
    logic [WIDTH-1:0]   result_d;

    assign advance  = idex_valid && (!ex_valid || mem_ready);
    assign id_ready = !idex_valid || advance;
    assign accept   = id_valid && id_ready;

    // ID/EX entry register: filled on acceptance, emptied when its entry moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid    <= 1'b0;
            idex_rs_val   <= '0;
            idex_rt_val   <= '0;
            idex_imm      <= '0;
            idex_rs       <= 5'd0;
            idex_rt       <= 5'd0;
            idex_rd       <= 5'd0;
            idex_alusrc   <= 1'b0;
            idex_aluop    <= 2'b00;
            idex_funct    <= 6'd0;
            idex_regwrite <= 1'b0;
        end else if (accept) begin
            idex_valid    <= 1'b1;
            idex_rs_val   <= id_rs_val;
            idex_rt_val   <= id_rt_val;
            idex_imm      <= id_imm;
            idex_rs       <= id_rs;
            idex_rt       <= id_rt;
            idex_rd       <= id_rd;
            idex_alusrc   <= id_alusrc;
            idex_aluop    <= id_aluop;
            idex_funct    <= id_funct;
            idex_regwrite <= id_regwrite;
        end else if (advance) begin
            idex_valid    <= 1'b0;
        end
    end

`ifdef EX_STAGE_FWD_EN
    // Pick the freshest rs value: the result sitting in EX/MEM beats the writeback bus.
    always_comb begin
        fwd_rs = idex_rs_val;
        if (ex_valid && ex_regwrite && (ex_rd != 5'd0) && (ex_rd == idex_rs)) begin
            fwd_rs = ex_result;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == idex_rs)) begin
            fwd_rs = wb_data;
        end
    end

    // Same priority for rt.
    always_comb begin
        fwd_rt = idex_rt_val;
        if (ex_valid && ex_regwrite && (ex_rd != 5'd0) && (ex_rd == idex_rt)) begin
            fwd_rt = ex_result;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == idex_rt)) begin
            fwd_rt = wb_data;
        end
    end
`else
    // Without forwarding the captured operands are used as-is and the bypass is ignored.
    logic unused_fwd;
    assign unused_fwd = ^{wb_we, wb_rd, wb_data, idex_rs, idex_rt};
    assign fwd_rs     = idex_rs_val;
    assign fwd_rt     = idex_rt_val;
`endif

    assign op_b = idex_alusrc ? idex_imm : fwd_rt;

    // Translate aluop/funct into an ALU select; unknown R-type functs are flagged illegal.
    always_comb begin
        alu_sel = ALU_ADD;
        illegal = 1'b0;
        case (idex_aluop)
            ALUOP_ADD: alu_sel = ALU_ADD;
            ALUOP_SUB: alu_sel = ALU_SUB;
            ALUOP_OR:  alu_sel = ALU_OR;
            default: begin
                case (idex_funct)
                    FUNCT_ADD: alu_sel = ALU_ADD;
                    FUNCT_SUB: alu_sel = ALU_SUB;
                    FUNCT_AND: alu_sel = ALU_AND;
                    FUNCT_OR:  alu_sel = ALU_OR;
                    FUNCT_SLT: alu_sel = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

    ex_stage_alu #(.WIDTH(WIDTH)) u_alu (
        .sel    (alu_sel),
        .a      (fwd_rs),
        .b      (op_b),
        .result (alu_result)
    );

    assign result_d = illegal ? '0 : alu_result;

    // EX/MEM output register: load on advance, drain on downstream accept, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_result   <= '0;
            ex_zero     <= 1'b0;
            ex_rd       <= 5'd0;
            ex_regwrite <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (advance) begin
            ex_valid    <= 1'b1;
            ex_result   <= result_d;
            ex_zero     <= (result_d == '0);
            ex_rd       <= idex_rd;
            ex_regwrite <= idex_regwrite && !illegal;
            ex_illegal  <= illegal;
        end else if (mem_ready) begin
            ex_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: handshake timing, ALU decode, stall/hold,
// forwarding (expectations follow EX_STAGE_FWD_EN) and asynchronous reset.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_alusrc;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_regwrite;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        mem_ready;
    logic [31:0] ex_result;
    logic        ex_zero;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    ex_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_rs_val   (id_rs_val),
        .id_rt_val   (id_rt_val),
        .id_imm      (id_imm),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_alusrc   (id_alusrc),
        .id_aluop    (id_aluop),
        .id_funct    (id_funct),
        .id_regwrite (id_regwrite),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .mem_ready   (mem_ready),
        .ex_result   (ex_result),
        .ex_zero     (ex_zero),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .ex_illegal  (ex_illegal)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] rsv, input logic [31:0] rtv,
                                 input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic alusrc, input logic [1:0] aluop,
                                 input logic [5:0] funct, input logic rw);
        id_valid    = v;
        id_rs_val   = rsv;
        id_rt_val   = rtv;
        id_imm      = imm;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_alusrc   = alusrc;
        id_aluop    = aluop;
        id_funct    = funct;
        id_regwrite = rw;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    logic [31:0] fwd_expect;
    logic [31:0] wb_expect;

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        idle();
        #2;
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_ex_result", ex_result, 32'd0);
        checkOutput("rst_ex_zero", {31'd0, ex_zero}, 32'd0);
        checkOutput("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        checkOutput("rst_ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        checkOutput("rst_ex_illegal", {31'd0, ex_illegal}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // sub 7-5 with two-cycle latency
        applyStimulus(1'b1, 32'd7, 32'd5, 32'd0, 5'd1, 5'd2, 5'd2, 1'b0, 2'b10, 6'b100010, 1'b1);
        step();
        idle();
        checkOutput("sub_not_yet_valid", {31'd0, ex_valid}, 32'd0);
        step();
        checkOutput("sub_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("sub_result", ex_result, 32'd2);
        checkOutput("sub_zero", {31'd0, ex_zero}, 32'd0);
        checkOutput("sub_rd", {27'd0, ex_rd}, 32'd2);
        checkOutput("sub_regwrite", {31'd0, ex_regwrite}, 32'd1);
        checkOutput("sub_illegal", {31'd0, ex_illegal}, 32'd0);
        step();
        checkOutput("sub_drained", {31'd0, ex_valid}, 32'd0);

        // slt signed compares, back to back
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 5'd6, 5'd4, 1'b0, 2'b10, 6'b101010, 1'b1);
        step();
        applyStimulus(1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd5, 5'd6, 5'd4, 1'b0, 2'b10, 6'b101010, 1'b1);
        step();
        idle();
        checkOutput("slt_neg_lt_pos", ex_result, 32'd1);
        step();
        checkOutput("slt_pos_lt_neg", ex_result, 32'd0);
        checkOutput("slt_zero_flag", {31'd0, ex_zero}, 32'd1);
        step();

        // full-throughput stream of mixed operations
        applyStimulus(1'b1, 32'd10, 32'd0, 32'hFFFF_FFFD, 5'd11, 5'd12, 5'd5, 1'b1, 2'b00, 6'd0, 1'b1);
        step();
        applyStimulus(1'b1, 32'h55, 32'h55, 32'd0, 5'd11, 5'd12, 5'd6, 1'b0, 2'b01, 6'd0, 1'b1);
        step();
        checkOutput("addi_result", ex_result, 32'd7);
        checkOutput("stream_id_ready", {31'd0, id_ready}, 32'd1);
        applyStimulus(1'b1, 32'hF0F0, 32'h0FF0, 32'd0, 5'd11, 5'd12, 5'd7, 1'b0, 2'b10, 6'b100100, 1'b1);
        step();
        checkOutput("subop_result", ex_result, 32'd0);
        checkOutput("subop_zero", {31'd0, ex_zero}, 32'd1);
        applyStimulus(1'b1, 32'h100, 32'd0, 32'd1, 5'd11, 5'd12, 5'd8, 1'b1, 2'b11, 6'd0, 1'b1);
        step();
        checkOutput("and_result", ex_result, 32'h00F0);
        applyStimulus(1'b1, 32'hA0, 32'h0B, 32'd0, 5'd11, 5'd12, 5'd9, 1'b0, 2'b10, 6'b100101, 1'b1);
        step();
        checkOutput("ori_result", ex_result, 32'h101);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd11, 5'd12, 5'd10, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        checkOutput("or_result", ex_result, 32'hAB);
        idle();
        step();
        checkOutput("add_wrap_result", ex_result, 32'd1);
        checkOutput("add_wrap_rd", {27'd0, ex_rd}, 32'd10);
        step();

        // illegal funct
        applyStimulus(1'b1, 32'h12, 32'h34, 32'd0, 5'd3, 5'd4, 5'd15, 1'b0, 2'b10, 6'b111111, 1'b1);
        step();
        idle();
        step();
        checkOutput("illegal_flag", {31'd0, ex_illegal}, 32'd1);
        checkOutput("illegal_regwrite", {31'd0, ex_regwrite}, 32'd0);
        checkOutput("illegal_result", ex_result, 32'd0);
        checkOutput("illegal_zero", {31'd0, ex_zero}, 32'd1);
        step();

        // downstream stall with three offered inputs
        mem_ready = 1'b0;
        applyStimulus(1'b1, 32'd1, 32'd2, 32'd0, 5'd13, 5'd14, 5'd20, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        applyStimulus(1'b1, 32'd9, 32'd4, 32'd0, 5'd13, 5'd14, 5'd21, 1'b0, 2'b10, 6'b100010, 1'b1);
        step();
        applyStimulus(1'b1, 32'd8, 32'd1, 32'd0, 5'd13, 5'd14, 5'd22, 1'b0, 2'b10, 6'b100101, 1'b1);
        checkOutput("stall_first_result", ex_result, 32'd3);
        step();
        checkOutput("stall_id_ready", {31'd0, id_ready}, 32'd0);
        checkOutput("stall_hold_result", ex_result, 32'd3);
        checkOutput("stall_hold_rd", {27'd0, ex_rd}, 32'd20);
        step();
        checkOutput("stall_id_ready_2", {31'd0, id_ready}, 32'd0);
        checkOutput("stall_hold_result_2", ex_result, 32'd3);
        checkOutput("stall_hold_valid", {31'd0, ex_valid}, 32'd1);
        mem_ready = 1'b1;
        #1;
        checkOutput("release_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        idle();
        checkOutput("release_second", ex_result, 32'd5);
        checkOutput("release_second_rd", {27'd0, ex_rd}, 32'd21);
        step();
        checkOutput("release_third", ex_result, 32'd9);
        checkOutput("release_third_rd", {27'd0, ex_rd}, 32'd22);
        step();
        checkOutput("release_drained", {31'd0, ex_valid}, 32'd0);

        // back-to-back dependency through r3
`ifdef EX_STAGE_FWD_EN
        fwd_expect = 32'd8;
        wb_expect  = 32'd105;
`else
        fwd_expect = 32'd20;
        wb_expect  = 32'd6;
`endif
        applyStimulus(1'b1, 32'd1, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        applyStimulus(1'b1, 32'd10, 32'd10, 32'd0, 5'd3, 5'd3, 5'd9, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        idle();
        checkOutput("dep_first_result", ex_result, 32'd4);
        step();
        checkOutput("dep_second_result", ex_result, fwd_expect);
        step();

        // writeback bypass into rs
        wb_we   = 1'b1;
        wb_rd   = 5'd7;
        wb_data = 32'd100;
        applyStimulus(1'b1, 32'd1, 32'd5, 32'd0, 5'd7, 5'd0, 5'd9, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        idle();
        step();
        checkOutput("wb_bypass_result", ex_result, wb_expect);
        wb_we = 1'b0;
        step();

        // reset with both stages full
        mem_ready = 1'b0;
        applyStimulus(1'b1, 32'd2, 32'd2, 32'd0, 5'd1, 5'd2, 5'd17, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        applyStimulus(1'b1, 32'd6, 32'd6, 32'd0, 5'd1, 5'd2, 5'd18, 1'b0, 2'b10, 6'b100000, 1'b1);
        step();
        checkOutput("full_before_reset", {31'd0, ex_valid}, 32'd1);
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("midrst_ex_result", ex_result, 32'd0);
        checkOutput("midrst_ex_rd", {27'd0, ex_rd}, 32'd0);
        checkOutput("midrst_ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        checkOutput("midrst_no_ghost", {31'd0, ex_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
